// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the mips_cpu_harvard test rig.
package mips_tb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      RUN,
      DRAIN,
      CHECK,
      DONE
   } rig_state_t;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] MIPS_NOP             = 32'h0000_0000;

endpackage

// File: rtl/mips_tb_prog_rom.sv
// Loadable program ROM: synchronous write, zero-latency fetch with range/alignment check.
module mips_tb_prog_rom
   import mips_tb_pkg::*;
#(
   parameter int unsigned ROM_DEPTH    = 64,
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   localparam int unsigned AW          = $clog2(ROM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [31:0]   raddr,
   output logic [31:0]   rdata,
   output logic          hit
);

   logic [31:0] mem [ROM_DEPTH];
   logic [31:0] offset;

   always_comb begin
      offset = raddr - RESET_VECTOR;
      // Wrap-around of the subtraction puts addresses below the vector out of range.
      hit    = (raddr[1:0] == 2'b00) && ((offset >> 2) < ROM_DEPTH);
      rdata  = hit ? mem[offset[AW+1:2]] : MIPS_NOP;
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/mips_harvard_test_rig.sv
// Run-control, halt/timeout detection and verdict for mips_cpu_harvard benches.
module mips_harvard_test_rig
   import mips_tb_pkg::*;
#(
   parameter int unsigned ROM_DEPTH    = 64,
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
   parameter int unsigned TIMEOUT      = 1024,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned RST_CYCLES   = 2,
   localparam int unsigned AW          = $clog2(ROM_DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic [31:0]   expected_v0,
   input  logic [31:0]   instr_address,
   output logic [31:0]   instr_readdata,
   input  logic [31:0]   register_v0,
   output logic          cpu_reset,
   output logic          cpu_clk_enable,
   output logic          done,
   output logic          pass,
   output logic          fail,
   output logic          timed_out,
   output logic          bad_fetch,
   output logic [31:0]   cycle_count
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
   localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
   localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN_CYCLES - 1);

   rig_state_t  state_q;
   logic [31:0] phase_cnt_q;
   logic [31:0] exp_v0_q;
   logic        fetch_hit;
   logic        idle_or_done;
   logic        v0_match;

   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
   assign v0_match     = (register_v0 == exp_v0_q);

   mips_tb_prog_rom #(
      .ROM_DEPTH    (ROM_DEPTH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_rom (
      .clk   (clk),
      .we    (load_en && idle_or_done),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (instr_address),
      .rdata (instr_readdata),
      .hit   (fetch_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         phase_cnt_q    <= '0;
         exp_v0_q       <= '0;
         cpu_reset      <= 1'b1;
         cpu_clk_enable <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail           <= 1'b0;
         timed_out      <= 1'b0;
         bad_fetch      <= 1'b0;
         cycle_count    <= '0;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q        <= RST;
                  phase_cnt_q    <= '0;
                  exp_v0_q       <= expected_v0;
                  cpu_reset      <= 1'b1;
                  cpu_clk_enable <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail           <= 1'b0;
                  timed_out      <= 1'b0;
                  bad_fetch      <= 1'b0;
                  cycle_count    <= '0;
               end
            end
            RST: begin
               if (phase_cnt_q == RST_LAST) begin
                  state_q     <= RUN;
                  phase_cnt_q <= '0;
                  cpu_reset   <= 1'b0;
               end else begin
                  phase_cnt_q <= phase_cnt_q + 32'd1;
               end
            end
            RUN: begin
               if (cycle_count != 32'hFFFF_FFFF) begin
                  cycle_count <= cycle_count + 32'd1;
               end
               if (!fetch_hit && (instr_address != HALT_ADDR)) begin
                  bad_fetch <= 1'b1;
               end
               // Halt takes priority over a coincident timeout.
               if (instr_address == HALT_ADDR) begin
                  state_q     <= DRAIN;
                  phase_cnt_q <= '0;
               end else if (cycle_count == TIMEOUT_LAST) begin
                  state_q        <= DONE;
                  cpu_clk_enable <= 1'b0;
                  done           <= 1'b1;
                  timed_out      <= 1'b1;
                  fail           <= 1'b1;
               end
            end
            DRAIN: begin
               if (phase_cnt_q == DRAIN_LAST) begin
                  state_q        <= CHECK;
                  cpu_clk_enable <= 1'b0;
               end else begin
                  phase_cnt_q <= phase_cnt_q + 32'd1;
               end
            end
            CHECK: begin
               state_q <= DONE;
               done    <= 1'b1;
               pass    <= v0_match && !bad_fetch;
               fail    <= !(v0_match && !bad_fetch);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_harvard_test_rig.sv
// Directed bench: a tiny delay-slot MIPS model runs programs loaded into the rig.
module tb_mips_harvard_test_rig;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic        start;
   logic [31:0] expected_v0;
   logic [31:0] instr_address;
   logic [31:0] instr_readdata;
   logic [31:0] register_v0;
   logic        cpu_reset;
   logic        cpu_clk_enable;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timed_out;
   logic        bad_fetch;
   logic [31:0] cycle_count;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mips_harvard_test_rig #(
      .TIMEOUT (64)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data),
      .start          (start),
      .expected_v0    (expected_v0),
      .instr_address  (instr_address),
      .instr_readdata (instr_readdata),
      .register_v0    (register_v0),
      .cpu_reset      (cpu_reset),
      .cpu_clk_enable (cpu_clk_enable),
      .done           (done),
      .pass           (pass),
      .fail           (fail),
      .timed_out      (timed_out),
      .bad_fetch      (bad_fetch),
      .cycle_count    (cycle_count)
   );

   // CPU model: addiu, ori, lui, beq, jr, with one branch delay slot.
   logic [31:0] pc  = 32'h0;
   logic [31:0] npc = 32'h4;
   logic [31:0] gpr [32];
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt;
   logic [15:0] imm;
   logic [31:0] simm, rs_val, rt_val;

   assign op            = instr_readdata[31:26];
   assign rs            = instr_readdata[25:21];
   assign rt            = instr_readdata[20:16];
   assign imm           = instr_readdata[15:0];
   assign fn            = instr_readdata[5:0];
   assign simm          = {{16{imm[15]}}, imm};
   assign rs_val        = gpr[rs];
   assign rt_val        = gpr[rt];
   assign instr_address = pc;
   assign register_v0   = gpr[2];

   always @(posedge clk) begin
      if (cpu_clk_enable) begin
         if (cpu_reset) begin
            pc  <= RV;
            npc <= RV + 32'd4;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
         end else begin
            pc  <= npc;
            npc <= npc + 32'd4;
            case (op)
               6'h00: if (fn == 6'h08) npc <= rs_val;
               6'h04: if (rs_val == rt_val) npc <= npc + (simm << 2);
               6'h09: if (rt != 5'd0) gpr[rt] <= rs_val + simm;
               6'h0D: if (rt != 5'd0) gpr[rt] <= rs_val | {16'h0, imm};
               6'h0F: if (rt != 5'd0) gpr[rt] <= {imm, 16'h0};
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] exp);
      @(negedge clk);
      start       = 1'b1;
      expected_v0 = exp;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'h0, done}, 32'h1);
   endtask

   task automatic load_prog1();
      load(6'd0, 32'h2402_0005);  // addiu $v0,$0,5
      load(6'd1, 32'h0000_0008);  // jr $0
      load(6'd2, 32'h0000_0000);  // nop
   endtask

   initial begin
      reset       = 1'b0;
      load_en     = 1'b0;
      load_addr   = '0;
      load_data   = '0;
      start       = 1'b0;
      expected_v0 = '0;
      repeat (3) @(negedge clk);
      check("rst cpu_reset", {31'h0, cpu_reset}, 32'h1);
      check("rst clk_en", {31'h0, cpu_clk_enable}, 32'h0);
      check("rst flags", {27'h0, done, pass, fail, timed_out, bad_fetch}, 32'h0);
      check("rst cycle_count", cycle_count, 32'h0);
      reset = 1'b1;

      // Passing run: RUN cycles fetch w0, w1, w2, then the halt fetch -> 4.
      load_prog1();
      pulse_start(32'd5);
      wait_done("p1 done");
      check("p1 pass/fail", {30'h0, pass, fail}, 32'h2);
      check("p1 timed_out", {31'h0, timed_out}, 32'h0);
      check("p1 cycle_count", cycle_count, 32'd4);
      check("p1 done outputs", {30'h0, cpu_reset, cpu_clk_enable}, 32'h0);

      // Mismatched expectation.
      pulse_start(32'd6);
      wait_done("p2 done");
      check("p2 pass/fail", {30'h0, pass, fail}, 32'h1);
      check("p2 timed_out", {31'h0, timed_out}, 32'h0);
      check("p2 bad_fetch", {31'h0, bad_fetch}, 32'h0);

      // Self-branch: beq $0,$0,-1 with nop delay slot, loops until timeout.
      load(6'd0, 32'h1000_FFFF);
      load(6'd1, 32'h0000_0000);
      pulse_start(32'd0);
      wait_done("p3 done");
      check("p3 timed_out", {31'h0, timed_out}, 32'h1);
      check("p3 pass/fail", {30'h0, pass, fail}, 32'h1);
      check("p3 cycle_count", cycle_count, 32'd64);
      check("p3 bad_fetch", {31'h0, bad_fetch}, 32'h0);
      // CPU froze with pc back on word 0.
      check("p3 fetch w0", instr_readdata, 32'h1000_FFFF);

      // Jump to misaligned 0xBFC00002 (jr $0 in delay slot), v0 still matches.
      load(6'd0, 32'h3C08_BFC0);  // lui $t0,0xBFC0
      load(6'd1, 32'h3508_0002);  // ori $t0,$t0,2
      load(6'd2, 32'h2402_0005);  // addiu $v0,$0,5
      load(6'd3, 32'h0100_0008);  // jr $t0
      load(6'd4, 32'h0000_0008);  // jr $0
      pulse_start(32'd5);
      wait_done("p4 done");
      check("p4 bad_fetch", {31'h0, bad_fetch}, 32'h1);
      check("p4 pass/fail", {30'h0, pass, fail}, 32'h1);
      check("p4 timed_out", {31'h0, timed_out}, 32'h0);

      // Reset mid-run, then re-run.
      load_prog1();
      pulse_start(32'd5);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid rst cpu_reset", {31'h0, cpu_reset}, 32'h1);
      check("mid rst clk_en", {31'h0, cpu_clk_enable}, 32'h0);
      check("mid rst done", {31'h0, done}, 32'h0);
      check("mid rst cycle_count", cycle_count, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      pulse_start(32'd5);
      wait_done("p5 done");
      check("p5 pass/fail", {30'h0, pass, fail}, 32'h2);
      check("p5 cycle_count", cycle_count, 32'd4);

      // Load during RUN must be ignored; second run sees the original word 0.
      pulse_start(32'd5);
      repeat (2) @(negedge clk);
      load_en   = 1'b1;
      load_addr = 6'd0;
      load_data = 32'h2402_0007;
      @(negedge clk);
      load_en   = 1'b0;
      wait_done("p6a done");
      check("p6a pass/fail", {30'h0, pass, fail}, 32'h2);
      check("p6a cycle_count", cycle_count, 32'd4);
      pulse_start(32'd5);
      wait_done("p6b done");
      check("p6b pass/fail", {30'h0, pass, fail}, 32'h2);
      check("p6b cycle_count", cycle_count, 32'd4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
